// File: rtl/divider_nbit_pkg.sv
// Shared definitions for the iterative restoring divider: FSM state encoding
// and a helper that sizes the bit counter from the operand width.
package divider_nbit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Bits needed to count down from w-1 to 0 (at least one bit).
    function automatic int cnt_bits(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/divider_nbit.sv
// Parametrised radix-2 restoring divider producing one quotient bit per clock.
// Supports a runtime signed mode (truncation toward zero, remainder takes the
// dividend's sign), flags divide-by-zero and signed overflow, and pulses done
// for one cycle when the result registers update.
module divider_nbit
    import divider_nbit_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             strt,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             not_valid,
    output logic             idle,
    output logic             done
);

    localparam int               CW      = cnt_bits(WIDTH);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CW-1:0]    CNT_TOP = CW'(WIDTH - 1);

    state_t           state_reg, state_next;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] dvd_reg;        // dividend magnitude, shifts out MSB-first; quotient shifts in at LSB
    logic [WIDTH-1:0] dvs_reg;        // divisor magnitude
    logic [WIDTH-1:0] rem_reg;        // partial remainder, always < divisor so WIDTH bits suffice
    logic             neg_q_reg;
    logic             neg_r_reg;
    logic [WIDTH-1:0] quotient_reg;
    logic [WIDTH-1:0] remainder_reg;
    logic             not_valid_reg;

    // Operand decode at the accept edge.
    logic             sgn;
    logic             dvd_neg;
    logic             dvs_neg;
    logic             div_zero;
    logic             overflow;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;

    assign sgn      = SIGNED_EN && signed_mode;
    assign dvd_neg  = sgn && dividend[WIDTH-1];
    assign dvs_neg  = sgn && divisor[WIDTH-1];
    assign div_zero = (divisor == '0);
    assign overflow = sgn && (dividend == MIN_NEG) && (divisor == '1);
    // MIN_NEG negates to itself, which read as unsigned is exactly its magnitude.
    assign dvd_mag  = dvd_neg ? ('0 - dividend) : dividend;
    assign dvs_mag  = dvs_neg ? ('0 - divisor)  : divisor;

    // Trial subtraction: shift in next dividend bit, subtract divisor with one
    // guard bit; the guard bit set means the difference went negative.
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             q_bit;

    assign shifted = {rem_reg, dvd_reg[WIDTH-1]};
    assign diff    = shifted - {1'b0, dvs_reg};
    assign q_bit   = ~diff[WIDTH];

    // Sign correction applied in the FIX step.
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    assign q_fix = neg_q_reg ? ('0 - dvd_reg) : dvd_reg;
    assign r_fix = neg_r_reg ? ('0 - rem_reg) : rem_reg;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and status outputs.
    always_comb begin
        state_next = state_reg;
        idle       = 1'b0;
        done       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                idle = 1'b1;
                if (strt) begin
                    state_next = (div_zero || overflow) ? ST_DONE : ST_CALC;
                end
            end
            ST_CALC: begin
                if (cnt_reg == '0) begin
                    state_next = ST_FIX;
                end
            end
            ST_FIX: begin
                state_next = ST_DONE;
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Datapath: operand capture, iteration, and result registers that load on entry to DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg       <= '0;
            dvd_reg       <= '0;
            dvs_reg       <= '0;
            rem_reg       <= '0;
            neg_q_reg     <= 1'b0;
            neg_r_reg     <= 1'b0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
            not_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (strt) begin
                        if (div_zero) begin
                            quotient_reg  <= '1;
                            remainder_reg <= dividend;
                            not_valid_reg <= 1'b1;
                        end else if (overflow) begin
                            quotient_reg  <= MIN_NEG;
                            remainder_reg <= '0;
                            not_valid_reg <= 1'b1;
                        end else begin
                            dvd_reg   <= dvd_mag;
                            dvs_reg   <= dvs_mag;
                            rem_reg   <= '0;
                            cnt_reg   <= CNT_TOP;
                            neg_q_reg <= dvd_neg ^ dvs_neg;
                            neg_r_reg <= dvd_neg;
                        end
                    end
                end
                ST_CALC: begin
                    rem_reg <= q_bit ? diff[WIDTH-1:0] : {rem_reg[WIDTH-2:0], dvd_reg[WIDTH-1]};
                    dvd_reg <= {dvd_reg[WIDTH-2:0], q_bit};
                    cnt_reg <= cnt_reg - 1'b1;
                end
                ST_FIX: begin
                    quotient_reg  <= q_fix;
                    remainder_reg <= r_fix;
                    not_valid_reg <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    assign quotient  = quotient_reg;
    assign remainder = remainder_reg;
    assign not_valid = not_valid_reg;

endmodule

// File: tb/tb_divider_nbit.sv
// Directed-vector bench for divider_nbit at WIDTH=8 with signed mode enabled.
module tb_divider_nbit;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         strt;
    logic         signed_mode;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         not_valid;
    logic         idle;
    logic         done;

    int n_cmp = 0;
    int n_bad = 0;

    divider_nbit #(.WIDTH(W), .SIGNED_EN(1'b1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .strt        (strt),
        .signed_mode (signed_mode),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .not_valid   (not_valid),
        .idle        (idle),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Waits (bounded) for idle, measured #1 after a rising edge.
    task automatic wait_idle();
        int k;
        k = 0;
        while (!idle && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        if (!idle) chk("idle_wait", {31'd0, idle}, 32'd1);
    endtask

    // One transaction: accept, scramble the inputs, measure done latency, check result.
    task automatic run_op(input string tag, input logic sm, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] eq,
                          input logic [W-1:0] er, input logic env, input int elat);
        int lat;
        wait_idle();
        strt = 1'b1; signed_mode = sm; dividend = a; divisor = b;
        @(posedge clk); #1;
        strt = 1'b0;
        dividend = W'($urandom); divisor = W'($urandom); signed_mode = ~sm;
        lat = 1;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        $display("op %s sm=%0d %02h/%02h -> q=%02h r=%02h nv=%0d lat=%0d",
                 tag, sm, a, b, quotient, remainder, not_valid, lat);
        chk({tag, "_q"},   32'(quotient),  32'(eq));
        chk({tag, "_r"},   32'(remainder), 32'(er));
        chk({tag, "_nv"},  32'(not_valid), 32'(env));
        chk({tag, "_lat"}, lat,            elat);
        @(posedge clk); #1;
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
        chk({tag, "_idle_back"},  32'(idle), 32'd1);
        chk({tag, "_q_held"},     32'(quotient), 32'(eq));
    endtask

    initial begin
        int lat;
        int extra;
        rst_n = 1'b0; strt = 1'b0; signed_mode = 1'b0; dividend = '0; divisor = '0;
        #12;
        chk("rst_q",    32'(quotient),  32'd0);
        chk("rst_r",    32'(remainder), 32'd0);
        chk("rst_nv",   32'(not_valid), 32'd0);
        chk("rst_idle", 32'(idle),      32'd1);
        chk("rst_done", 32'(done),      32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        //      tag        sm    a      b      q      r      nv    lat
        run_op("u200_7",   1'b0, 8'd200, 8'd7,  8'd28,  8'd4,  1'b0, 10);
        run_op("u_div0",   1'b0, 8'h5A, 8'h00, 8'hFF, 8'h5A, 1'b1, 1);
        run_op("s_m7_2",   1'b1, 8'hF9, 8'h02, 8'hFD, 8'hFF, 1'b0, 10);
        run_op("s_7_m2",   1'b1, 8'h07, 8'hFE, 8'hFD, 8'h01, 1'b0, 10);
        run_op("s_ovf",    1'b1, 8'h80, 8'hFF, 8'h80, 8'h00, 1'b1, 1);
        run_op("u255_1",   1'b0, 8'hFF, 8'h01, 8'hFF, 8'h00, 1'b0, 10);
        run_op("u5_10",    1'b0, 8'd5,  8'd10, 8'd0,  8'd5,  1'b0, 10);
        run_op("u80_ff",   1'b0, 8'h80, 8'hFF, 8'h00, 8'h80, 1'b0, 10);
        run_op("s_m128_2", 1'b1, 8'h80, 8'h02, 8'hC0, 8'h00, 1'b0, 10);
        run_op("s_m7_m2",  1'b1, 8'hF9, 8'hFE, 8'h03, 8'hFF, 1'b0, 10);
        run_op("s_div0",   1'b1, 8'h64, 8'h00, 8'hFF, 8'h64, 1'b1, 1);
        run_op("s_m128_1", 1'b1, 8'h80, 8'h01, 8'h80, 8'h00, 1'b0, 10);
        run_op("s_7f_m128",1'b1, 8'h7F, 8'h80, 8'h00, 8'h7F, 1'b0, 10);
        run_op("u_after",  1'b0, 8'd100,8'd9,  8'd11, 8'd1,  1'b0, 10);

        // strt mid-CALC with new operands must be ignored.
        wait_idle();
        strt = 1'b1; signed_mode = 1'b0; dividend = 8'd200; divisor = 8'd7;
        @(posedge clk); #1;
        strt = 1'b0;
        lat = 1;
        repeat (3) begin
            @(posedge clk); #1;
            lat++;
        end
        strt = 1'b1; dividend = 8'd10; divisor = 8'd3;
        @(posedge clk); #1;
        lat++;
        strt = 1'b0;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        $display("op ignore_strt 200/7 with mid-CALC strt 10/3 -> q=%0d r=%0d lat=%0d", quotient, remainder, lat);
        chk("ign_q",   32'(quotient),  32'd28);
        chk("ign_r",   32'(remainder), 32'd4);
        chk("ign_lat", lat,            10);
        extra = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (done) extra++;
        end
        chk("ign_single_done", extra, 0);

        // Asynchronous reset in the middle of CALC.
        wait_idle();
        strt = 1'b1; signed_mode = 1'b0; dividend = 8'd99; divisor = 8'd5;
        @(posedge clk); #1;
        strt = 1'b0;
        repeat (4) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        $display("op reset_mid_calc -> q=%0d r=%0d nv=%0d idle=%0d done=%0d", quotient, remainder, not_valid, idle, done);
        chk("arst_q",    32'(quotient),  32'd0);
        chk("arst_r",    32'(remainder), 32'd0);
        chk("arst_nv",   32'(not_valid), 32'd0);
        chk("arst_idle", 32'(idle),      32'd1);
        chk("arst_done", 32'(done),      32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        extra = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done) extra++;
        end
        chk("arst_no_done", extra, 0);
        run_op("post_rst", 1'b0, 8'd99, 8'd5, 8'd19, 8'd4, 1'b0, 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
